// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared defaults and types for the sprite ROM fetch arbiter.
package sprite_pkg;

   localparam int          DEF_ADDR_W     = 13;
   localparam int          DEF_DATA_W     = 24;
   localparam int          DEF_LEN_W      = 6;
   localparam logic [23:0] DEF_CHROMA_KEY = 24'hFF00FF;

   typedef enum logic {IDLE, BURST} arb_state_t;

   typedef logic [DEF_ADDR_W-1:0] sprite_addr_t;

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Requester, ROM and return-path signals of the sprite fetch arbiter.
interface sprite_fetch_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = sprite_pkg::DEF_ADDR_W,
   parameter int DATA_W  = sprite_pkg::DEF_DATA_W,
   parameter int LEN_W   = sprite_pkg::DEF_LEN_W
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_base;
   logic [NUM_REQ*LEN_W-1:0]  req_len;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        done;
   logic [ADDR_W-1:0]         rom_addr;
   logic [DATA_W-1:0]         rom_data;
   logic                      rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic [ID_W-1:0]           rd_id;
   logic                      rd_last;
   logic                      rd_transp;

   modport master (
      input  req, req_base, req_len, rom_data,
      output gnt, done, rom_addr, rd_valid, rd_data, rd_id, rd_last, rd_transp
   );

   modport slave (
      output req, req_base, req_len, rom_data,
      input  gnt, done, rom_addr, rd_valid, rd_data, rd_id, rd_last, rd_transp
   );
endinterface

// File: rtl/sprite_fetch_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     win,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   logic [IDX_W-1:0] cand;

   always_comb begin
      win  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 0; i < N; i++) begin
         cand = IDX_W'((int'(ptr) + i) % N);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      if (any) win[idx] = 1'b1;
   end
endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin burst arbiter sharing one sprite ROM among the lane drawers.
// Optional chroma-key flag on returned pixels: define SPRITE_CHROMA_KEY_EN.
//
// state | meaning
// IDLE  | no issue this cycle; arbitrate pending requests
// BURST | one ROM address issued per cycle for the granted requester
module sprite_fetch_arbiter
   import sprite_pkg::*;
#(
   parameter int               NUM_REQ    = 4,
   parameter int               ADDR_W     = DEF_ADDR_W,
   parameter int               DATA_W     = DEF_DATA_W,
   parameter int               LEN_W      = DEF_LEN_W,
   parameter int               ROM_LAT    = 1,
   parameter logic [DATA_W-1:0] CHROMA_KEY = DATA_W'(DEF_CHROMA_KEY)
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   sprite_fetch_arbiter_if.master bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = LEN_W + 1;

   arb_state_t         state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    cur_id;
   logic [ADDR_W-1:0]  base_q;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] done_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               iss_valid;
   logic               iss_last;

   logic [NUM_REQ-1:0] win;
   logic [ID_W-1:0]    win_idx;
   logic               win_any;
   logic [ADDR_W-1:0]  win_base;
   logic [LEN_W-1:0]   win_len_raw;
   logic [CNT_W-1:0]   win_len;
   logic [CNT_W-1:0]   nxt_cnt;
   logic               nxt_last;
   logic [ID_W-1:0]    nxt_ptr;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req (bus.req),
      .ptr (rr_ptr),
      .win (win),
      .idx (win_idx),
      .any (win_any)
   );

   always_comb begin
      win_base    = bus.req_base[win_idx*ADDR_W +: ADDR_W];
      win_len_raw = bus.req_len[win_idx*LEN_W +: LEN_W];
      win_len     = (win_len_raw == '0) ? CNT_W'(1 << LEN_W) : {1'b0, win_len_raw};
      nxt_cnt     = cnt + 1'b1;
      // A requester dropping req mid-burst makes the issue loaded at this edge the final one.
      nxt_last    = (nxt_cnt == len_q - 1'b1) || !bus.req[cur_id];
      nxt_ptr     = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         base_q    <= '0;
         len_q     <= '0;
         cnt       <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         addr_q    <= '0;
         iss_valid <= 1'b0;
         iss_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  state     <= BURST;
                  cur_id    <= win_idx;
                  base_q    <= win_base;
                  len_q     <= win_len;
                  cnt       <= '0;
                  gnt_q     <= win;
                  addr_q    <= win_base;
                  iss_valid <= 1'b1;
                  iss_last  <= (win_len == CNT_W'(1));
                  done_q    <= (win_len == CNT_W'(1)) ? win : '0;
               end else begin
                  gnt_q     <= '0;
                  done_q    <= '0;
                  iss_valid <= 1'b0;
                  iss_last  <= 1'b0;
               end
            end
            BURST: begin
               if (iss_last) begin
                  state     <= IDLE;
                  gnt_q     <= '0;
                  done_q    <= '0;
                  iss_valid <= 1'b0;
                  iss_last  <= 1'b0;
                  rr_ptr    <= nxt_ptr;
               end else begin
                  cnt      <= nxt_cnt;
                  addr_q   <= base_q + ADDR_W'(nxt_cnt);
                  iss_last <= nxt_last;
                  done_q   <= nxt_last ? gnt_q : '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Return-path tags follow each issue through the ROM latency.
   logic [ROM_LAT-1:0] pv;
   logic [ROM_LAT-1:0] pl;
   logic [ID_W-1:0]    pid [ROM_LAT];

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         pv <= '0;
         pl <= '0;
         for (int s = 0; s < ROM_LAT; s++) pid[s] <= '0;
      end else begin
         pv[0]  <= iss_valid;
         pl[0]  <= iss_valid & iss_last;
         pid[0] <= cur_id;
         for (int s = 1; s < ROM_LAT; s++) begin
            pv[s]  <= pv[s-1];
            pl[s]  <= pl[s-1];
            pid[s] <= pid[s-1];
         end
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.rom_addr = addr_q;
   assign bus.rd_valid = pv[ROM_LAT-1];
   assign bus.rd_last  = pl[ROM_LAT-1];
   assign bus.rd_id    = pid[ROM_LAT-1];
   assign bus.rd_data  = bus.rom_data;

`ifdef SPRITE_CHROMA_KEY_EN
   assign bus.rd_transp = bus.rd_valid && (bus.rom_data == CHROMA_KEY);
`else
   assign bus.rd_transp = 1'b0;
`endif

endmodule
